// File: rtl/if_id_queue.sv
// IF/ID decoupling queue: a DEPTH-entry FIFO of {pc, inst} between fetch and decode,
// feeding a registered output stage that emits a zero bubble when idle or flushed.
module if_id_queue #(
  parameter int ADDR_W = 32,
  parameter int INST_W = 32,
  parameter int DEPTH  = 4,
  parameter int CNT_W  = $clog2(DEPTH + 1)
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              flush,
  input  logic              if_valid,
  input  logic [ADDR_W-1:0] if_pc,
  input  logic [INST_W-1:0] if_inst,
  output logic              if_ready,
  input  logic              id_stall,
  output logic              id_valid,
  output logic [ADDR_W-1:0] id_pc,
  output logic [INST_W-1:0] id_inst,
  output logic [CNT_W-1:0]  count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic [ADDR_W-1:0] pc_mem   [DEPTH];
  logic [INST_W-1:0] inst_mem [DEPTH];

  logic [PTR_W-1:0]  rd_ptr_reg;
  logic [PTR_W-1:0]  wr_ptr_reg;
  logic [CNT_W-1:0]  count_reg;
  logic              id_valid_reg;
  logic [ADDR_W-1:0] id_pc_reg;
  logic [INST_W-1:0] id_inst_reg;

  logic accept;
  logic queue_empty;
  logic mem_we;

  // Ready depends only on the registered count, never on id_stall.
  assign if_ready    = (count_reg < FULL_CNT);
  assign accept      = if_valid && if_ready;
  assign queue_empty = (count_reg == '0);
  // Bypass (empty, not stalled) skips the queue; everything else that is accepted is stored.
  assign mem_we      = accept && !RST && !flush && (id_stall || !queue_empty);

  always_ff @(posedge CLK) begin
    if (mem_we) begin
      pc_mem[wr_ptr_reg]   <= if_pc;
      inst_mem[wr_ptr_reg] <= if_inst;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST || flush) begin
      rd_ptr_reg   <= '0;
      wr_ptr_reg   <= '0;
      count_reg    <= '0;
      id_valid_reg <= 1'b0;
      id_pc_reg    <= '0;
      id_inst_reg  <= '0;
    end else if (id_stall) begin
      if (accept) begin
        wr_ptr_reg <= wr_ptr_reg + 1'b1;
        count_reg  <= count_reg + 1'b1;
      end
    end else if (!queue_empty) begin
      id_valid_reg <= 1'b1;
      id_pc_reg    <= pc_mem[rd_ptr_reg];
      id_inst_reg  <= inst_mem[rd_ptr_reg];
      rd_ptr_reg   <= rd_ptr_reg + 1'b1;
      if (accept) begin
        wr_ptr_reg <= wr_ptr_reg + 1'b1;
      end else begin
        count_reg <= count_reg - 1'b1;
      end
    end else if (accept) begin
      id_valid_reg <= 1'b1;
      id_pc_reg    <= if_pc;
      id_inst_reg  <= if_inst;
    end else begin
      id_valid_reg <= 1'b0;
      id_pc_reg    <= '0;
      id_inst_reg  <= '0;
    end
  end

  assign id_valid = id_valid_reg;
  assign id_pc    = id_pc_reg;
  assign id_inst  = id_inst_reg;
  assign count    = count_reg;

endmodule

// File: tb/tb_if_id_queue.sv
// Directed self-checking bench for if_id_queue (DEPTH=4): reset, bypass, fill/full,
// drain with wrap, flush and flush-over-stall.
module tb_if_id_queue;

  logic        clk;
  logic        rst;
  logic        flush;
  logic        if_valid;
  logic [31:0] if_pc;
  logic [31:0] if_inst;
  logic        if_ready;
  logic        id_stall;
  logic        id_valid;
  logic [31:0] id_pc;
  logic [31:0] id_inst;
  logic [2:0]  count;

  int errors = 0;
  int checks = 0;

  if_id_queue #(.ADDR_W(32), .INST_W(32), .DEPTH(4)) dut (
    .CLK      (clk),
    .RST      (rst),
    .flush    (flush),
    .if_valid (if_valid),
    .if_pc    (if_pc),
    .if_inst  (if_inst),
    .if_ready (if_ready),
    .id_stall (id_stall),
    .id_valid (id_valid),
    .id_pc    (id_pc),
    .id_inst  (id_inst),
    .count    (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Instruction word tied to its pc so id_inst can be checked independently.
  function automatic logic [31:0] inst_of(input logic [31:0] pc);
    return pc ^ 32'hA5A5_0000;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [31:0] pc);
    if_valid = v;
    if_pc    = pc;
    if_inst  = inst_of(pc);
  endtask

  task automatic chk_out(input string tag, input logic v, input logic [31:0] pc, input logic [2:0] cnt);
    chk({tag, ".valid"}, {31'd0, id_valid}, {31'd0, v});
    chk({tag, ".pc"}, id_pc, pc);
    chk({tag, ".inst"}, id_inst, v ? inst_of(pc) : 32'd0);
    chk({tag, ".count"}, {29'd0, count}, {29'd0, cnt});
    $display("step %-14s valid=%0d pc=%h inst=%h count=%0d ready=%0d",
             tag, id_valid, id_pc, id_inst, count, if_ready);
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; id_stall = 1'b0;
    drive(1'b1, 32'hDEAD_0000);
    step(); step();
    rst = 1'b0; drive(1'b0, 32'h0);
    chk_out("reset", 1'b0, 32'h0, 3'd0);
    chk("reset.ready", {31'd0, if_ready}, 32'd1);
    step();
    chk_out("reset_idle", 1'b0, 32'h0, 3'd0);

    // Bypass streaming
    drive(1'b1, 32'h100); step(); chk_out("byp0", 1'b1, 32'h100, 3'd0);
    drive(1'b1, 32'h104); step(); chk_out("byp1", 1'b1, 32'h104, 3'd0);
    drive(1'b1, 32'h108); step(); chk_out("byp2", 1'b1, 32'h108, 3'd0);
    drive(1'b0, 32'h0);   step(); chk_out("byp_bubble", 1'b0, 32'h0, 3'd0);

    // Fill to full under stall
    id_stall = 1'b1;
    drive(1'b1, 32'h200); step(); chk_out("fill1", 1'b0, 32'h0, 3'd1);
    drive(1'b1, 32'h204); step(); chk_out("fill2", 1'b0, 32'h0, 3'd2);
    drive(1'b1, 32'h208); step(); chk_out("fill3", 1'b0, 32'h0, 3'd3);
    chk("fill3.ready", {31'd0, if_ready}, 32'd1);
    drive(1'b1, 32'h20C); step(); chk_out("fill4", 1'b0, 32'h0, 3'd4);
    chk("full.ready", {31'd0, if_ready}, 32'd0);
    drive(1'b1, 32'h210); step(); chk_out("full_hold", 1'b0, 32'h0, 3'd4);

    // Drain with concurrent push; 0x210 is only accepted once ready reasserts
    id_stall = 1'b0;
    step(); chk_out("drain0", 1'b1, 32'h200, 3'd3);
    chk("drain0.ready", {31'd0, if_ready}, 32'd1);
    step(); chk_out("drain1", 1'b1, 32'h204, 3'd3);
    drive(1'b1, 32'h214); step(); chk_out("drain2", 1'b1, 32'h208, 3'd3);
    drive(1'b1, 32'h218); step(); chk_out("drain3", 1'b1, 32'h20C, 3'd3);
    drive(1'b0, 32'h0);
    step(); chk_out("drain4", 1'b1, 32'h210, 3'd2);
    step(); chk_out("drain5", 1'b1, 32'h214, 3'd1);
    step(); chk_out("drain6", 1'b1, 32'h218, 3'd0);
    step(); chk_out("drain_bubble", 1'b0, 32'h0, 3'd0);

    // Flush mid-queue
    id_stall = 1'b1;
    drive(1'b1, 32'h280); step();
    drive(1'b1, 32'h284); step();
    drive(1'b1, 32'h288); step(); chk_out("preflush", 1'b0, 32'h0, 3'd3);
    flush = 1'b1; drive(1'b1, 32'h300); step();
    chk_out("flush", 1'b0, 32'h0, 3'd0);
    flush = 1'b0; id_stall = 1'b0;
    drive(1'b1, 32'h400); step(); chk_out("post_flush", 1'b1, 32'h400, 3'd0);
    drive(1'b0, 32'h0);   step(); chk_out("post_flush_idle", 1'b0, 32'h0, 3'd0);

    // Flush beats stall
    drive(1'b1, 32'h500); step(); chk_out("pre_fs", 1'b1, 32'h500, 3'd0);
    id_stall = 1'b1; drive(1'b1, 32'h504); step(); chk_out("stall_hold", 1'b1, 32'h500, 3'd1);
    flush = 1'b1; drive(1'b0, 32'h0); step(); chk_out("flush_stall", 1'b0, 32'h0, 3'd0);
    flush = 1'b0; id_stall = 1'b0;

    // Reset mid-operation
    id_stall = 1'b1;
    drive(1'b1, 32'h600); step(); step();
    chk_out("pre_rst", 1'b0, 32'h0, 3'd2);
    rst = 1'b1; step(); rst = 1'b0; id_stall = 1'b0; drive(1'b0, 32'h0);
    chk_out("mid_rst", 1'b0, 32'h0, 3'd0);
    step(); chk_out("mid_rst_idle", 1'b0, 32'h0, 3'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
